hdr_weighted_accum: RTL and testbench

- Per-pixel weighted accumulator directly downstream of the weight-coefficient stage in the HDR merge path.
- Consumes one sample per exposure: the weight w(Z) and a signed log-radiance term (g(Z) − ln Δt).
- Accumulates NUM_EXP samples per pixel and emits numerator Σw·rad and denominator Σw to the divider stage.
- Valid/ready handshake on both sides; full-stall backpressure.

---
 rtl/hdr_weighted_accum.sv | 140 ++++++++++++++
 tb/tb_hdr_weighted_accum.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdr_weighted_accum.sv
// hdr_weighted_accum: accumulates NUM_EXP (weight, log-radiance) samples per pixel
//   and emits numerator sum(w*rad) and denominator sum(w) to the divider stage.
// Latency: the last sample accepted in cycle t gives out_valid in cycle t+2.
//   Throughput is one sample per cycle.
// Backpressure: full stall. When out_valid is high and out_ready is low,
//   in_ready drops and every register holds its value.
// Ports:
//   clk, reset                        clock, async active-high reset
//   in_valid/in_ready                 sample handshake
//   in_first, in_weight, in_rad       sample: exposure-0 flag, weight, signed radiance
//   out_valid/out_ready               result handshake
//   out_num, out_den                  result sums
//   err_sync                          one-cycle pulse on an exposure framing error
`timescale 1ns/1ps
module hdr_weighted_accum #(
  parameter int W_WIDTH   = 8,
  parameter int RAD_WIDTH = 16,
  parameter int NUM_EXP   = 3,
  parameter int NUM_WIDTH = W_WIDTH + RAD_WIDTH + 3,
  parameter int DEN_WIDTH = W_WIDTH + 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_first,
  input  logic [W_WIDTH-1:0]          in_weight,
  input  logic signed [RAD_WIDTH-1:0] in_rad,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [NUM_WIDTH-1:0] out_num,
  output logic [DEN_WIDTH-1:0]        out_den,
  output logic                        err_sync
);

  localparam int PROD_W = W_WIDTH + RAD_WIDTH + 1;
  localparam int CNT_W  = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_EXP - 1);

  logic stall, accept, upd;

  // exposure counter and stage-1 registers
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic                     s1_vld, s1_last, s1_restart, s1_drop;
  logic signed [PROD_W-1:0] s1_prod;
  logic [W_WIDTH-1:0]       s1_w;

  // stage-2 accumulators
  logic signed [NUM_WIDTH-1:0] acc_num, base_num, sum_num;
  logic [DEN_WIDTH-1:0]        acc_den, base_den, sum_den;

  // combinational stage-1 terms
  logic signed [PROD_W-1:0] w_ext, rad_ext, prod_c;
  logic                     restart_c, drop_c, last_c;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;
  assign upd      = s1_vld & ~stall;

  always_comb begin
    // Both operands extended to the full product width, so the product is exact.
    w_ext     = $signed({{(RAD_WIDTH + 1){1'b0}}, in_weight});
    rad_ext   = $signed({{(W_WIDTH + 1){in_rad[RAD_WIDTH-1]}}, in_rad});
    prod_c    = w_ext * rad_ext;

    // in_first always restarts a pixel; a non-first sample at index 0 is orphaned.
    restart_c = in_first & (cnt != '0);
    drop_c    = ~in_first & (cnt == '0);
    last_c    = ~in_first & (cnt == LAST_IDX);

    cnt_nxt = cnt + CNT_W'(1);
    if (in_first)    cnt_nxt = CNT_W'(1);
    else if (drop_c) cnt_nxt = '0;
    else if (last_c) cnt_nxt = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      s1_vld     <= 1'b0;
      s1_last    <= 1'b0;
      s1_restart <= 1'b0;
      s1_drop    <= 1'b0;
      s1_prod    <= '0;
      s1_w       <= '0;
    end else if (!stall) begin
      s1_vld <= accept;
      if (accept) begin
        cnt        <= cnt_nxt;
        s1_prod    <= prod_c;
        s1_w       <= in_weight;
        s1_last    <= last_c;
        s1_restart <= restart_c;
        s1_drop    <= drop_c;
      end
    end
  end

  always_comb begin
    // A restarting sample discards whatever partial sums were collected.
    base_num = s1_restart ? '0 : acc_num;
    base_den = s1_restart ? '0 : acc_den;
    sum_num  = base_num + {{(NUM_WIDTH - PROD_W){s1_prod[PROD_W-1]}}, s1_prod};
    sum_den  = base_den + {{(DEN_WIDTH - W_WIDTH){1'b0}}, s1_w};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_num   <= '0;
      acc_den   <= '0;
      out_num   <= '0;
      out_den   <= '0;
      out_valid <= 1'b0;
      err_sync  <= 1'b0;
    end else begin
      err_sync <= upd & (s1_drop | s1_restart);

      if (upd && !s1_drop) begin
        if (s1_last) begin
          acc_num <= '0;
          acc_den <= '0;
        end else begin
          acc_num <= sum_num;
          acc_den <= sum_den;
        end
      end

      // A new result can only load when not stalled, so held data stays stable.
      if (upd && !s1_drop && s1_last) begin
        out_num   <= sum_num;
        out_den   <= sum_den;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hdr_weighted_accum.sv
`timescale 1ns/1ps
module tb_hdr_weighted_accum;

  localparam int NW = 27;
  localparam int DW = 11;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_first;
  logic [7:0]           in_weight;
  logic signed [15:0]   in_rad;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [NW-1:0] out_num;
  logic [DW-1:0]        out_den;
  logic                 err_sync;

  int checks = 0;
  int errors = 0;

  hdr_weighted_accum dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
    .in_weight(in_weight), .in_rad(in_rad),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_num(out_num), .out_den(out_den), .err_sync(err_sync)
  );

  always #5 clk = ~clk;

  // Present one input for one clock edge, then settle 1ns after the edge.
  task automatic step(input logic v, input logic f, input logic [7:0] w, input logic signed [15:0] r);
    in_valid  = v;
    in_first  = f;
    in_weight = w;
    in_rad    = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'd0, 16'sd0);
  endtask

  // Bounded wait for out_valid. found=0 means it never appeared.
  task automatic wait_out(output logic found);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) begin
        found = 1'b1;
        break;
      end
      idle();
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_valid = 0; in_first = 0; in_weight = 0; in_rad = 0; out_ready = 1;
    reset = 1'b1;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_num !== '0 || out_den !== '0 || err_sync !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b num=%0d den=%0d err=%b, want all 0",
               out_valid, out_num, out_den, err_sync);
    end
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    step(1, 1, 8'd10, 16'sd200);
    step(1, 0, 8'd100, -16'sd50);
    step(1, 0, 8'd1, 16'sd1000);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_early: out_valid got %b one cycle after the last accept, want 0", out_valid);
    end
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_num !== NW'(-2000) || out_den !== DW'(111)) begin
      errors++;
      $display("FAIL basic_result: got v=%b num=%0d den=%0d, want v=1 num=-2000 den=111",
               out_valid, out_num, out_den);
    end
    idle();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drop: out_valid got %b after the handshake, want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]         w[6]  = '{8'd1, 8'd1, 8'd1, 8'd128, 8'd128, 8'd128};
    logic signed [15:0] r[6]  = '{16'sd1, 16'sd1, 16'sd1, -16'sd32768, -16'sd32768, -16'sd32768};
    logic               f[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic signed [NW-1:0] got_num[2];
    logic [DW-1:0]        got_den[2];
    int got_cyc[2];
    int n = 0;
    for (int c = 0; c < 10; c++) begin
      if (c < 6) step(1'b1, f[c], w[c], r[c]);
      else idle();
      if (out_valid) begin
        if (n < 2) begin
          got_num[n] = out_num;
          got_den[n] = out_den;
          got_cyc[n] = c;
        end
        n++;
      end
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL b2b_count: got %0d result cycles, want 2", n);
    end else begin
      checks++;
      if (got_num[0] !== NW'(3) || got_den[0] !== DW'(3)) begin
        errors++;
        $display("FAIL b2b_first: got num=%0d den=%0d, want 3/3", got_num[0], got_den[0]);
      end
      checks++;
      if (got_num[1] !== NW'(-12582912) || got_den[1] !== DW'(384)) begin
        errors++;
        $display("FAIL b2b_second: got num=%0d den=%0d, want -12582912/384", got_num[1], got_den[1]);
      end
      checks++;
      if (got_cyc[0] != 3 || got_cyc[1] - got_cyc[0] != 3) begin
        errors++;
        $display("FAIL b2b_timing: got cycles %0d,%0d, want 3,6", got_cyc[0], got_cyc[1]);
      end
    end
  endtask

  task automatic test_stall();
    logic found;
    int bad = 0;
    // Pixel A: 2*5 + 3*-7 + 4*1 = -7, den 9
    step(1, 1, 8'd2, 16'sd5);
    step(1, 0, 8'd3, -16'sd7);
    step(1, 0, 8'd4, 16'sd1);
    out_ready = 1'b0;
    // Pixel B sample 0 is still accepted: the result is not out yet.
    step(1, 1, 8'd5, 16'sd100);
    checks++;
    if (out_valid !== 1'b1 || out_num !== NW'(-7) || out_den !== DW'(9)) begin
      errors++;
      $display("FAIL stall_result: got v=%b num=%0d den=%0d, want v=1 num=-7 den=9",
               out_valid, out_num, out_den);
    end
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 8'd6, -16'sd1);
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_num !== NW'(-7) || out_den !== DW'(9)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold: got %0d cycles with moved outputs or in_ready=1, want 0", bad);
    end
    out_ready = 1'b1;
    step(1, 0, 8'd6, -16'sd1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: out_valid got %b after the handshake, want 0", out_valid);
    end
    step(1, 0, 8'd7, 16'sd2);
    idle();
    wait_out(found);
    // Pixel B: 500 - 6 + 14 = 508, den 18
    checks++;
    if (!found || out_num !== NW'(508) || out_den !== DW'(18)) begin
      errors++;
      $display("FAIL stall_next: got found=%b num=%0d den=%0d, want found=1 num=508 den=18",
               found, out_num, out_den);
    end
    idle();
  endtask

  task automatic test_first_midpixel();
    step(1, 1, 8'd1, 16'sd1);
    step(1, 0, 8'd1, 16'sd2);
    step(1, 1, 8'd5, 16'sd10);
    checks++;
    if (err_sync !== 1'b0) begin
      errors++;
      $display("FAIL restart_early: err_sync got %b before the restart update, want 0", err_sync);
    end
    step(1, 0, 8'd5, 16'sd20);
    checks++;
    if (err_sync !== 1'b1) begin
      errors++;
      $display("FAIL restart_pulse: err_sync got %b, want 1", err_sync);
    end
    step(1, 0, 8'd5, 16'sd30);
    checks++;
    if (err_sync !== 1'b0) begin
      errors++;
      $display("FAIL restart_pulse_len: err_sync got %b on the second cycle, want 0", err_sync);
    end
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_num !== NW'(300) || out_den !== DW'(15)) begin
      errors++;
      $display("FAIL restart_result: got v=%b num=%0d den=%0d, want v=1 num=300 den=15",
               out_valid, out_num, out_den);
    end
    idle();
  endtask

  task automatic test_orphan_after_reset();
    apply_reset();
    step(1, 0, 8'd9, 16'sd9);
    step(1, 1, 8'd2, 16'sd3);
    checks++;
    if (err_sync !== 1'b1) begin
      errors++;
      $display("FAIL orphan_pulse: err_sync got %b, want 1", err_sync);
    end
    step(1, 0, 8'd2, 16'sd3);
    checks++;
    if (err_sync !== 1'b0) begin
      errors++;
      $display("FAIL orphan_counter: err_sync got %b on the in_first sample, want 0", err_sync);
    end
    step(1, 0, 8'd2, 16'sd3);
    idle();
    checks++;
    if (out_valid !== 1'b1 || out_num !== NW'(18) || out_den !== DW'(6)) begin
      errors++;
      $display("FAIL orphan_result: got v=%b num=%0d den=%0d, want v=1 num=18 den=6",
               out_valid, out_num, out_den);
    end
    idle();
  endtask

  task automatic test_reset_midpixel();
    logic found;
    step(1, 1, 8'd50, 16'sd50);
    step(1, 0, 8'd50, 16'sd50);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_num !== '0 || out_den !== '0 || err_sync !== 1'b0) begin
      errors++;
      $display("FAIL midreset_async: got v=%b num=%0d den=%0d err=%b, want all 0",
               out_valid, out_num, out_den, err_sync);
    end
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(1, 1, 8'd1, 16'sd7);
    step(1, 0, 8'd1, 16'sd7);
    step(1, 0, 8'd1, 16'sd7);
    wait_out(found);
    checks++;
    if (!found || out_num !== NW'(21) || out_den !== DW'(3)) begin
      errors++;
      $display("FAIL midreset_next: got found=%b num=%0d den=%0d, want found=1 num=21 den=3",
               found, out_num, out_den);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_first_midpixel();
    test_orphan_after_reset();
    test_reset_midpixel();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
